// File: rtl/eth_udp_tx_framer_pkg.sv
// Shared constants, header layouts and state type for the UDP transmit framer.
package eth_udp_tx_framer_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam int unsigned ETH_MIN_FRAME  = 60;
    localparam int unsigned HDR_BYTES      = 42;
    localparam int unsigned HDR_BITS       = HDR_BYTES * 8;

    // Last index of each fixed-length section (byte counter restarts per section)
    localparam logic [10:0] CSUM_LAST = 11'd9;
    localparam logic [10:0] ETH_LAST  = 11'd13;
    localparam logic [10:0] IP_LAST   = 11'd19;
    localparam logic [10:0] UDP_LAST  = 11'd7;

    // Payloads shorter than this need zero padding up to ETH_MIN_FRAME
    localparam logic [15:0] NO_PAD_LEN   = 16'(ETH_MIN_FRAME - HDR_BYTES);
    localparam logic [15:0] PAD_LAST_REF = NO_PAD_LEN - 16'd1;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } hdr_cfg_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] eth_type;
    } eth_hdr_t;

    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ip_hdr_t;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] len;
        logic [15:0] checksum;
    } udp_hdr_t;

    typedef enum logic [2:0] {
        StIdle, StCsum, StEth, StIp, StUdp, StPayload, StPad, StIfg
    } tx_state_e;

    // Halfword idx (0 = first on the wire) of an IP header
    function automatic logic [15:0] ip_hword(input ip_hdr_t hdr, input logic [3:0] idx);
        logic [159:0] flat;
        flat = 160'(hdr) << {idx, 4'b0000};
        return flat[159:144];
    endfunction

endpackage

// File: rtl/eth_udp_tx_framer_checksum.sv
// Serial one's-complement adder for the IPv4 header checksum, one halfword per cycle.
module ip_hdr_checksum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add,
    input  logic [15:0] hword,
    output logic [15:0] result
);

    logic [19:0] acc_q, acc_d;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Next accumulator; result is taken from it so the final add is visible on its own edge
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (add) begin
            acc_d = acc_q + {4'h0, hword};
        end
        fold1  = {1'b0, acc_d[15:0]} + {13'd0, acc_d[19:16]};
        fold2  = fold1[15:0] + {15'd0, fold1[16]};
        result = ~fold2;
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/eth_udp_tx_framer.sv
// Wraps a payload byte stream in Ethernet II + IPv4 + UDP headers, one byte per accepted cycle.
module eth_udp_tx_framer
    import eth_udp_tx_framer_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter logic [7:0]  IP_TTL      = 8'h40,
    parameter int unsigned IFG_CYCLES  = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] payload_len,
    input  hdr_cfg_t    hdr_cfg,
    input  logic [7:0]  payload_data,
    input  logic        payload_valid,
    output logic        payload_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy,
    output logic        len_err
);

    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

    tx_state_e            state_q, state_d;
    logic [10:0]          cnt_q, cnt_d;
    logic [15:0]          len_q;
    hdr_cfg_t             cfg_q;
    logic [15:0]          ip_id_q;
    logic [HDR_BITS-1:0]  hdr_q;
    logic                 len_err_q, len_err_d;

    logic accept, load_hdr, shift_hdr, ip_id_inc, csum_clear, csum_add;
    logic [15:0] csum_word, csum_result, cnt_ext;
    logic pay_end, pad_end, short_frame;
    eth_hdr_t eth_hdr;
    ip_hdr_t  ip_hdr, ip_hdr_cs;
    udp_hdr_t udp_hdr;

    ip_hdr_checksum u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (csum_clear),
        .add    (csum_add),
        .hword  (csum_word),
        .result (csum_result)
    );

    // Header fields from the latched request; checksum field is zero while summing
    always_comb begin
        eth_hdr.dst_mac    = cfg_q.dst_mac;
        eth_hdr.src_mac    = cfg_q.src_mac;
        eth_hdr.eth_type   = ETH_TYPE_IPV4;
        ip_hdr.ver_ihl     = 8'h45;
        ip_hdr.tos         = 8'h00;
        ip_hdr.total_len   = len_q + 16'd28;
        ip_hdr.id          = ip_id_q;
        ip_hdr.flags_frag  = 16'h4000;
        ip_hdr.ttl         = IP_TTL;
        ip_hdr.proto       = IP_PROTO_UDP;
        ip_hdr.checksum    = 16'h0000;
        ip_hdr.src_ip      = cfg_q.src_ip;
        ip_hdr.dst_ip      = cfg_q.dst_ip;
        ip_hdr_cs          = ip_hdr;
        ip_hdr_cs.checksum = csum_result;
        udp_hdr.src_port   = cfg_q.src_port;
        udp_hdr.dst_port   = cfg_q.dst_port;
        udp_hdr.len        = len_q + 16'd8;
        udp_hdr.checksum   = 16'h0000;
        csum_word          = ip_hword(ip_hdr, cnt_q[3:0]);
        cnt_ext            = {5'd0, cnt_q};
        short_frame        = len_q < NO_PAD_LEN;
        pay_end            = cnt_ext == len_q - 16'd1;
        pad_end            = cnt_ext == PAD_LAST_REF - len_q;
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        tx_last       = 1'b0;
        payload_ready = 1'b0;
        csum_clear    = 1'b0;
        csum_add      = 1'b0;
        load_hdr      = 1'b0;
        shift_hdr     = 1'b0;
        accept        = 1'b0;
        len_err_d     = 1'b0;
        ip_id_inc     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (payload_len != 16'd0 && payload_len <= MAX_LEN) begin
                        accept     = 1'b1;
                        csum_clear = 1'b1;
                        cnt_d      = '0;
                        state_d    = StCsum;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            StCsum: begin
                csum_add = 1'b1;
                cnt_d    = cnt_q + 11'd1;
                if (cnt_q == CSUM_LAST) begin
                    load_hdr = 1'b1;
                    cnt_d    = '0;
                    state_d  = StEth;
                end
            end
            StEth, StIp, StUdp: begin
                tx_valid = 1'b1;
                tx_data  = hdr_q[HDR_BITS-1 -: 8];
                if (tx_ready) begin
                    shift_hdr = 1'b1;
                    cnt_d     = cnt_q + 11'd1;
                    if (state_q == StEth && cnt_q == ETH_LAST) begin
                        cnt_d   = '0;
                        state_d = StIp;
                    end
                    if (state_q == StIp && cnt_q == IP_LAST) begin
                        cnt_d   = '0;
                        state_d = StUdp;
                    end
                    if (state_q == StUdp && cnt_q == UDP_LAST) begin
                        cnt_d   = '0;
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                tx_valid      = payload_valid;
                tx_data       = payload_valid ? payload_data : 8'h00;
                tx_last       = payload_valid && pay_end && !short_frame;
                payload_ready = payload_valid && tx_ready;
                if (payload_ready) begin
                    cnt_d = cnt_q + 11'd1;
                    if (pay_end) begin
                        cnt_d = '0;
                        if (short_frame) begin
                            state_d = StPad;
                        end else begin
                            ip_id_inc = 1'b1;
                            state_d   = StIfg;
                        end
                    end
                end
            end
            StPad: begin
                tx_valid = 1'b1;
                tx_last  = pad_end;
                if (tx_ready) begin
                    cnt_d = cnt_q + 11'd1;
                    if (pad_end) begin
                        cnt_d     = '0;
                        ip_id_inc = 1'b1;
                        state_d   = StIfg;
                    end
                end
            end
            StIfg: begin
                cnt_d = cnt_q + 11'd1;
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy    = state_q != StIdle;
    assign len_err = len_err_q;

    // FSM state, section byte counter and rejection pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    // Request capture on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cfg_q <= '0;
        end else if (accept) begin
            len_q <= payload_len;
            cfg_q <= hdr_cfg;
        end
    end

    // Header shift register, loaded once the checksum is final
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_q <= '0;
        end else if (load_hdr) begin
            hdr_q <= {eth_hdr, ip_hdr_cs, udp_hdr};
        end else if (shift_hdr) begin
            hdr_q <= {hdr_q[HDR_BITS-9:0], 8'h00};
        end
    end

    // IP identification, advanced as each frame completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_id_q <= '0;
        end else if (ip_id_inc) begin
            ip_id_q <= ip_id_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_udp_tx_framer.sv
// Randomized self-checking bench for eth_udp_tx_framer against a byte-list frame model.
module tb_eth_udp_tx_framer;
    import eth_udp_tx_framer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] payload_len = '0;
    hdr_cfg_t    hdr_cfg = '0;
    logic [7:0]  payload_data = '0;
    logic        payload_valid = 1'b0;
    logic        payload_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        len_err;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  pay_q[$];
    logic [15:0] ip_id_m = 16'h0000;

    always #5 clk = ~clk;

    eth_udp_tx_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .payload_len   (payload_len),
        .hdr_cfg       (hdr_cfg),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .len_err       (len_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_tx_valid"}, tx_valid, 0);
        check_eq({tag, "_tx_data"}, tx_data, 0);
        check_eq({tag, "_tx_last"}, tx_last, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_len_err"}, len_err, 0);
        check_eq({tag, "_payload_ready"}, payload_ready, 0);
    endtask

    task automatic push_be(input logic [47:0] v, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Expected wire bytes for one frame, straight from the header layout rules
    task automatic build_frame(input int len, input hdr_cfg_t cfg, input logic [15:0] id);
        logic [7:0]  ip[20];
        logic [15:0] tot, csum, ulen;
        logic [31:0] sum;
        tot = 16'(len + 28);
        ulen = 16'(len + 8);
        ip[0] = 8'h45; ip[1] = 8'h00; ip[2] = tot[15:8]; ip[3] = tot[7:0];
        ip[4] = id[15:8]; ip[5] = id[7:0]; ip[6] = 8'h40; ip[7] = 8'h00;
        ip[8] = 8'h40; ip[9] = 8'h11; ip[10] = 8'h00; ip[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            ip[12+i] = cfg.src_ip[31-8*i -: 8];
            ip[16+i] = cfg.dst_ip[31-8*i -: 8];
        end
        sum = 0;
        for (int i = 0; i < 10; i++) sum = sum + {16'h0, ip[2*i], ip[2*i+1]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        csum = ~sum[15:0];
        ip[10] = csum[15:8];
        ip[11] = csum[7:0];
        exp_q.delete();
        push_be(cfg.dst_mac, 6);
        push_be(cfg.src_mac, 6);
        push_be(48'h0800, 2);
        for (int i = 0; i < 20; i++) exp_q.push_back(ip[i]);
        push_be(48'(cfg.src_port), 2);
        push_be(48'(cfg.dst_port), 2);
        push_be(48'(ulen), 2);
        push_be(48'h0, 2);
        for (int i = 0; i < len; i++) exp_q.push_back(pay_q[i]);
        while (exp_q.size() < 60) exp_q.push_back(8'h00);
    endtask

    task automatic rand_cfg(output hdr_cfg_t c);
        c.dst_mac  = 48'({$urandom(), $urandom()});
        c.src_mac  = 48'({$urandom(), $urandom()});
        c.src_ip   = $urandom();
        c.dst_ip   = $urandom();
        c.src_port = 16'($urandom());
        c.dst_port = 16'($urandom());
    endtask

    task automatic rand_payload(input int len);
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom()));
    endtask

    // One frame: start, cycle-by-cycle compare against the model, then the gap.
    // stall_idx: frame byte at which tx_ready is forced low 5 cycles.
    // starve_idx / abort_idx: payload byte at which valid drops 3 cycles / reset hits.
    task automatic run_frame(input int len, input hdr_cfg_t cfg, input int ready_pct,
                             input int valid_pct, input int stall_idx, input int starve_idx,
                             input int abort_idx);
        int idx, c, first_c, total, stall, starve;
        bit stall_done, starve_done, in_pay, exp_v, aborted;
        build_frame(len, cfg, ip_id_m);
        total = exp_q.size();
        idx = 0; c = 1; first_c = -1; stall = 0; starve = 0;
        stall_done = 0; starve_done = 0; aborted = 0;
        @(negedge clk);
        start = 1'b1; payload_len = 16'(len); hdr_cfg = cfg; payload_valid = 1'b0; tx_ready = 1'b1;
        #1 check_eq("busy_at_start", busy, 0);
        while (idx < total && c < 20000) begin
            @(negedge clk);
            start = 1'b0;
            in_pay = idx >= 42 && idx < 42 + len;
            if (!stall_done && idx == stall_idx) begin stall = 5; stall_done = 1; end
            if (!starve_done && in_pay && idx - 42 == starve_idx) begin
                starve = 3; starve_done = 1;
            end
            tx_ready = (stall > 0) ? 1'b0 : ($urandom_range(99, 0) < 32'(ready_pct));
            payload_valid = (starve > 0) ? 1'b0 : ($urandom_range(99, 0) < 32'(valid_pct));
            payload_data = in_pay ? pay_q[idx-42] : 8'($urandom());
            if (in_pay && idx - 42 == abort_idx) begin
                rst_n = 1'b0;
                #1 check_quiet("reset_mid_frame");
                aborted = 1;
                break;
            end
            #1;
            exp_v = (c <= 10) ? 1'b0 : (in_pay ? payload_valid : 1'b1);
            check_eq("tx_valid", tx_valid, exp_v);
            check_eq("busy_in_frame", busy, 1);
            check_eq("payload_ready", payload_ready, in_pay && payload_valid && tx_ready);
            if (tx_valid && exp_v) begin
                if (first_c < 0) first_c = c;
                check_eq($sformatf("tx_data[%0d]", idx), tx_data, exp_q[idx]);
                check_eq($sformatf("tx_last[%0d]", idx), tx_last, idx == total - 1);
            end
            if (tx_valid && tx_ready) idx++;
            if (stall > 0) stall--;
            if (starve > 0) starve--;
            c++;
        end
        if (aborted) begin
            repeat (3) @(negedge clk);
            start = 1'b0; payload_valid = 1'b0; tx_ready = 1'b0;
            #1 check_quiet("in_reset");
            @(negedge clk);
            rst_n = 1'b1;
            ip_id_m = 16'h0000;
        end else begin
            check_eq("frame_bytes", idx, total);
            check_eq("first_valid_cycle", first_c, 11);
            // Gap: start held high must be ignored; busy drops after exactly IFG cycles
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                start = 1'b1; payload_len = 16'd10; tx_ready = 1'b1;
                #1;
                check_eq("ifg_busy", busy, 1);
                check_eq("ifg_tx_valid", tx_valid, 0);
            end
            @(negedge clk);
            start = 1'b0;
            #1 check_eq("busy_after_ifg", busy, 0);
            ip_id_m = ip_id_m + 16'd1;
        end
    endtask

    task automatic check_len_err(input logic [15:0] len);
        @(negedge clk);
        start = 1'b1; payload_len = len;
        @(negedge clk);
        start = 1'b0;
        #1;
        check_eq("len_err_pulse", len_err, 1);
        check_eq("len_err_busy", busy, 0);
        @(negedge clk);
        #1;
        check_eq("len_err_clear", len_err, 0);
        check_eq("len_err_idle", busy, 0);
    endtask

    initial begin
        hdr_cfg_t cfg;
        repeat (3) @(negedge clk);
        #1 check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Known checksum frame (ipId 0)
        rand_cfg(cfg);
        cfg.src_ip = 32'hC0A80001;
        cfg.dst_ip = 32'hC0A800C7;
        rand_payload(87);
        run_frame(87, cfg, 100, 100, -1, -1, -1);

        // Short payload padded to 60 bytes
        rand_cfg(cfg);
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(4, cfg, 100, 100, -1, -1, -1);

        // Backpressure inside the IP header, then payload starvation
        rand_cfg(cfg);
        rand_payload(30);
        run_frame(30, cfg, 100, 100, 20, -1, -1);
        rand_cfg(cfg);
        rand_payload(40);
        run_frame(40, cfg, 100, 100, -1, 10, -1);

        check_len_err(16'd0);
        check_len_err(16'd1473);

        // Pad boundary and the largest payload
        rand_cfg(cfg);
        rand_payload(17);
        run_frame(17, cfg, 80, 80, -1, -1, -1);
        rand_cfg(cfg);
        rand_payload(18);
        run_frame(18, cfg, 80, 80, -1, -1, -1);
        rand_cfg(cfg);
        rand_payload(1472);
        run_frame(1472, cfg, 100, 100, -1, -1, -1);

        for (int i = 0; i < 8; i++) begin
            int len;
            len = (i % 2 == 0) ? $urandom_range(30, 1) : $urandom_range(200, 1);
            rand_cfg(cfg);
            rand_payload(len);
            run_frame(len, cfg, 70, 70, -1, -1, -1);
        end

        // Reset mid-payload, then two back-to-back frames (ipId 0 and 1)
        rand_cfg(cfg);
        rand_payload(60);
        run_frame(60, cfg, 100, 100, -1, -1, 30);
        rand_cfg(cfg);
        rand_payload(25);
        run_frame(25, cfg, 100, 100, -1, -1, -1);
        rand_cfg(cfg);
        rand_payload(9);
        run_frame(9, cfg, 90, 90, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
